// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared encodings and bit-timing helpers for the UART program loader
package loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_t;

    localparam int BITS_PER_BYTE = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int half_bit(input int clk_freq, input int baud);
        return clks_per_bit(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver with input synchronizer and registered byte/error pulses
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF  = half_bit(CLK_FREQ, BAUD);
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    logic             sync1;
    logic             sync2;
    rx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;

    // Synchronizer resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    baud_cnt <= '0;
                    if (!sync2) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        rx_byte  <= {sync2, rx_byte[7:1]};
                        if (bit_cnt == 3'(BITS_PER_BYTE - 1)) begin
                            state <= RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt   <= '0;
                        byte_valid <= sync2;
                        frame_err  <= !sync2;
                        state      <= RX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= RX_IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - packs received byte pairs into instruction words and streams them to memory
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int          CLK_FREQ = 100_000_000,
    parameter int          BAUD     = 9600,
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] END_WORD = 16'hFFFF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              UART_TXD_IN,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              load_done,
    output logic              frame_err
);

    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic [7:0]        hi_byte;
    phase_t            phase;
    logic [ADDR_W-1:0] addr_cnt;
    logic [15:0]       word;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk        (CLK),
        .rst        (RST),
        .rxd        (UART_TXD_IN),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign word = {hi_byte, rx_byte};

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            load_done <= 1'b0;
            hi_byte   <= '0;
            phase     <= PH_HI;
            addr_cnt  <= '0;
        end else begin
            wr_en <= 1'b0;
            // A framing error drops any half-assembled word so the next byte is a high byte.
            if (frame_err) begin
                phase <= PH_HI;
            end else if (byte_valid && !load_done) begin
                if (phase == PH_HI) begin
                    hi_byte <= rx_byte;
                    phase   <= PH_LO;
                end else begin
                    phase <= PH_HI;
                    if (word == END_WORD) begin
                        load_done <= 1'b1;
                    end else begin
                        wr_en    <= 1'b1;
                        wr_addr  <= addr_cnt;
                        wr_data  <= word;
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                        // Memory is full after the top address; stop before wrapping onto word 0.
                        if (addr_cnt == {ADDR_W{1'b1}}) begin
                            load_done <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - scoreboard bench for uart_program_loader at 16 clocks per bit
module tb_uart_program_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line = 1'b1;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        load_done;
    logic        frame_err;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  wr_count = 0;
    int  fe_cycles = 0;
    int  wr_base;
    int  fe_base;

    uart_program_loader #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .ADDR_W   (8),
        .END_WORD (16'hFFFF)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .UART_TXD_IN (line),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .load_done   (load_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        wr_t e;
        forever begin
            @(negedge clk);
            if (wr_en) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%h:%h required=no_write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(wr_data), 32'(e.data));
                end
            end
            if (frame_err) fe_cycles++;
        end
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int stop_clks, input logic stop_val);
        line = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            repeat (16) @(negedge clk);
        end
        line = stop_val;
        repeat (stop_clks) @(negedge clk);
        line = 1'b1;
    endtask

    task automatic send_word(input logic [15:0] w, input int stop_clks);
        send_byte(w[15:8], stop_clks, 1'b1);
        send_byte(w[7:0], stop_clks, 1'b1);
    endtask

    task automatic push(input logic [7:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        line = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(4);
        wr_base = wr_count;
        fe_base = fe_cycles;
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        do_reset();
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        chk("reset_wr_data", 32'(wr_data), 32'd0);
        chk("reset_load_done", 32'(load_done), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);

        // single word
        push(8'h00, 16'h1234);
        send_word(16'h1234, 16);
        idle(8);
        chk("t1_pending", 32'(exp_q.size()), 32'd0);
        chk("t1_writes", 32'(wr_count - wr_base), 32'd1);
        chk("t1_load_done", 32'(load_done), 32'd0);

        // three words then terminator
        do_reset();
        push(8'h00, 16'hABCD);
        push(8'h01, 16'h0001);
        push(8'h02, 16'h7F80);
        send_word(16'hABCD, 16);
        send_word(16'h0001, 16);
        send_word(16'h7F80, 16);
        send_word(16'hFFFF, 16);
        idle(8);
        chk("t2_pending", 32'(exp_q.size()), 32'd0);
        chk("t2_writes", 32'(wr_count - wr_base), 32'd3);
        chk("t2_load_done", 32'(load_done), 32'd1);

        // short low glitch is a false start
        do_reset();
        line = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        chk("t3_frame_err", 32'(fe_cycles - fe_base), 32'd0);
        chk("t3_writes", 32'(wr_count - wr_base), 32'd0);
        push(8'h00, 16'h5A3C);
        send_word(16'h5A3C, 16);
        idle(8);
        chk("t3_pending", 32'(exp_q.size()), 32'd0);

        // framing error resyncs the byte phase
        do_reset();
        send_byte(8'h11, 16, 1'b1);
        send_byte(8'h66, 12, 1'b0);
        idle(40);
        chk("t4_frame_err_cycles", 32'(fe_cycles - fe_base), 32'd1);
        chk("t4_writes_before", 32'(wr_count - wr_base), 32'd0);
        push(8'h00, 16'h55AA);
        send_word(16'h55AA, 16);
        idle(8);
        chk("t4_pending", 32'(exp_q.size()), 32'd0);
        chk("t4_load_done", 32'(load_done), 32'd0);

        // fill all 256 addresses
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i);
            push(a, {a, ~a});
            send_word({a, ~a}, 12);
        end
        idle(8);
        chk("t5_pending", 32'(exp_q.size()), 32'd0);
        chk("t5_writes", 32'(wr_count - wr_base), 32'd256);
        chk("t5_load_done", 32'(load_done), 32'd1);
        chk("t5_last_addr", 32'(wr_addr), 32'hFF);
        send_word(16'h1234, 16);
        idle(8);
        chk("t5_writes_after", 32'(wr_count - wr_base), 32'd256);

        // reset in the middle of a byte
        send_byte(8'h11, 16, 1'b1);
        line = 1'b0;
        repeat (16) @(negedge clk);
        line = 1'b1;
        repeat (16) @(negedge clk);
        line = 1'b0;
        repeat (20) @(negedge clk);
        rst  = 1'b1;
        line = 1'b1;
        @(negedge clk);
        chk("t6_wr_en", 32'(wr_en), 32'd0);
        chk("t6_wr_addr", 32'(wr_addr), 32'd0);
        chk("t6_wr_data", 32'(wr_data), 32'd0);
        chk("t6_load_done", 32'(load_done), 32'd0);
        chk("t6_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        idle(40);
        wr_base = wr_count;
        push(8'h00, 16'hBEEF);
        send_word(16'hBEEF, 16);
        idle(8);
        chk("t6_pending", 32'(exp_q.size()), 32'd0);
        chk("t6_writes", 32'(wr_count - wr_base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
